// File: rtl/fifo_uart_tx_if.sv
// FIFO-read and serial-line bundle between the FIFO/enable source (master) and the UART drain (slave).
// Clock and reset are carried as plain ports on the modules, not through this bundle.
interface fifo_uart_tx_if;
  logic       en;
  logic       fifo_empty;
  logic       fifo_read;
  logic [7:0] fifo_rdata;
  logic       tx;
  logic       busy;
  logic [2:0] diag_state;
  logic [2:0] diag_bit;

  modport master (
    output en, fifo_empty, fifo_rdata,
    input  fifo_read, tx, busy, diag_state, diag_bit
  );

  modport slave (
    input  en, fifo_empty, fifo_rdata,
    output fifo_read, tx, busy, diag_state, diag_bit
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops one byte at a time from an upstream FIFO and sends it as an 8N1 frame; the read comes 1 cycle after the
// deciding edge and the start bit 2 cycles after that. A frame is 10*CLKS_PER_BIT cycles and en gates only new pops.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  fifo_uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_param_check
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit;
  logic                 w_bit_end;
  logic                 w_take;
  logic                 w_tx;

  assign w_bit_end = (r_cnt == LAST_CNT);
  assign w_take    = bus.en && !bus.fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_take) w_next = POP;
      POP:     w_next = LOAD;
      LOAD:    w_next = START;
      START:   if (w_bit_end) w_next = DATA;
      DATA:    if (w_bit_end && (r_bit == 3'd7)) w_next = STOP;
      STOP:    if (w_bit_end) w_next = w_take ? POP : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The counter restarts on every state change so each state's bit period starts aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
    end else begin
      if ((w_next != r_state) || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == LOAD) begin
        r_shift <= bus.fifo_rdata;
      end else if ((r_state == DATA) && w_bit_end) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end

      if (r_state == DATA) begin
        if (w_bit_end) r_bit <= r_bit + 3'd1;
      end else begin
        r_bit <= '0;
      end
    end
  end

  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = r_shift[0];
      default: w_tx = 1'b1;
    endcase
  end

  assign bus.tx         = w_tx;
  assign bus.fifo_read  = (r_state == POP);
  assign bus.busy       = (r_state != IDLE);
  assign bus.diag_state = r_state;
  assign bus.diag_bit   = r_bit;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the block and a line-level UART receiver decodes tx,
// comparing frames and timing against the written byte sequence.
module tb_fifo_uart_tx;
  localparam int N     = 4;
  localparam int FRAME = 10 * N;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  fifo_uart_tx_if bus();

  fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         starts[$];
  int         nframes  = 0;
  int         nreads   = 0;
  int         last_pop = -100;
  logic       en_s, empty_s, rst_s;
  logic       prev_read = 1'b0;

  logic [9:0] rx_fr;
  logic       rx_cur;
  logic       rx_ok, rx_abort;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic void fifo_push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    bus.fifo_empty = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (bus.diag_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, bus.diag_state, s);
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (nframes < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, nframes, target);
  endtask

  // FIFO model: a read strobe seen in a cycle pops the head, so rdata is valid in the following cycle.
  always begin : mon
    @(posedge clk);
    cyc++;
    en_s    = bus.en;
    empty_s = bus.fifo_empty;
    rst_s   = rst;
    @(negedge clk);
    if (!rst_s && !rst) begin
      check_eq("busy_vs_state", bus.busy, bus.diag_state != 3'd0);
      if (bus.fifo_read === 1'b1) begin
        check_eq("read_when_enabled_nonempty", {en_s, empty_s}, 2'b10);
        check_eq("read_single_cycle", prev_read, 1'b0);
        check_eq("read_no_underflow", fifo_q.size() != 0, 1'b1);
        if (fifo_q.size() != 0) bus.fifo_rdata = fifo_q.pop_front();
        bus.fifo_empty = (fifo_q.size() == 0);
        nreads++;
        last_pop = cyc;
      end
    end
    prev_read = (bus.fifo_read === 1'b1);
  end

  // Line receiver: every bit must hold for N cycles; a reset inside a frame discards that byte.
  always begin : rx
    @(negedge clk);
    if (rst === 1'b0 && bus.tx === 1'b0) begin
      rx_ok    = 1'b1;
      rx_abort = 1'b0;
      rx_fr    = '0;
      rx_cur   = 1'b0;
      check_eq("pop_to_start", cyc, last_pop + 2);
      starts.push_back(cyc);
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        if (rst !== 1'b0) begin
          rx_abort = 1'b1;
          break;
        end
        if (k % N == 0) begin
          rx_cur = bus.tx;
          rx_fr  = {bus.tx, rx_fr[9:1]};
        end else if (bus.tx !== rx_cur) begin
          rx_ok = 1'b0;
        end
      end
      if (rx_abort) begin
        if (exp_q.size() != 0) exp_q.delete(0);
      end else begin
        check_eq("rx_bits_stable", rx_ok, 1'b1);
        check_eq("rx_start_bit", rx_fr[0], 1'b0);
        check_eq("rx_stop_bit", rx_fr[9], 1'b1);
        check_eq("rx_frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check_eq("rx_byte", rx_fr[8:1], exp_q.pop_front());
        nframes++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_r, base_f, c, s0, next_val, wr, guard;
    logic [7:0] b0, b1;

    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    tick();
    tick();
    rst    = 1'b0;
    bus.en = 1'b1;

    // Reset then idle with an empty FIFO.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_tx", bus.tx, 1'b1);
      check_eq("idle_read", bus.fifo_read, 1'b0);
      check_eq("idle_busy", bus.busy, 1'b0);
      check_eq("idle_state", bus.diag_state, 3'd0);
    end

    // Single byte 0xA5: latency and frame length.
    tick();
    base_r = nreads;
    base_f = nframes;
    fifo_push(8'hA5);
    c = cyc;
    wait_cyc(c + 3 + FRAME - 1);
    check_eq("t2_last_cycle_is_stop", bus.diag_state, 3'd5);
    @(negedge clk);
    check_eq("t2_idle_after_frame", bus.diag_state, 3'd0);
    check_eq("t2_frames", nframes - base_f, 1);
    check_eq("t2_read_latency", last_pop, c + 1);
    check_eq("t2_start_latency", starts[starts.size()-1], c + 3);
    check_eq("t2_read_count", nreads - base_r, 1);
    check_eq("t2_fifo_drained", fifo_q.size(), 0);

    // Back-to-back frames from a preloaded FIFO.
    tick();
    base_r = nreads;
    base_f = nframes;
    s0     = starts.size();
    fifo_push(8'h01);
    fifo_push(8'h02);
    fifo_push(8'h03);
    c = cyc;
    wait_cyc(c + 3 + FRAME);
    check_eq("t3_gap1_tx", bus.tx, 1'b1);
    check_eq("t3_gap1_state", bus.diag_state, 3'd1);
    wait_cyc(c + 4 + FRAME);
    check_eq("t3_gap2_tx", bus.tx, 1'b1);
    check_eq("t3_gap2_state", bus.diag_state, 3'd2);
    wait_cyc(c + 3 + 2 * (FRAME + 2) + FRAME);
    check_eq("t3_idle_after", bus.diag_state, 3'd0);
    check_eq("t3_frames", nframes - base_f, 3);
    check_eq("t3_reads", nreads - base_r, 3);
    check_eq("t3_starts", starts.size() - s0, 3);
    if (starts.size() - s0 == 3) begin
      check_eq("t3_spacing_1_2", starts[s0+1] - starts[s0], FRAME + 2);
      check_eq("t3_spacing_2_3", starts[s0+2] - starts[s0+1], FRAME + 2);
    end

    // Enable dropped mid-frame: current frame finishes, no further pop.
    tick();
    base_r = nreads;
    base_f = nframes;
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    fifo_push(b0);
    fifo_push(b1);
    wait_state(3'd4, 50, "t4_reach_data");
    tick();
    bus.en = 1'b0;
    wait_state(3'd0, 100, "t4_back_to_idle");
    for (int i = 0; i < 10; i++) @(negedge clk);
    check_eq("t4_one_read", nreads - base_r, 1);
    check_eq("t4_fifo_holds_one", fifo_q.size(), 1);
    check_eq("t4_one_frame", nframes - base_f, 1);
    check_eq("t4_still_idle", bus.diag_state, 3'd0);
    tick();
    bus.en = 1'b1;
    wait_frames(base_f + 2, 120, "t4_second_frame");
    wait_state(3'd0, 10, "t4_final_idle");
    check_eq("t4_two_reads", nreads - base_r, 2);
    check_eq("t4_fifo_drained", fifo_q.size(), 0);

    // Reset during DATA bit 3: byte discarded, next byte sent intact.
    tick();
    base_r = nreads;
    base_f = nframes;
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    fifo_push(b0);
    fifo_push(b1);
    guard = 0;
    while (!(bus.diag_state === 3'd4 && bus.diag_bit === 3'd3) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("t5_reach_bit3", {bus.diag_state, bus.diag_bit}, {3'd4, 3'd3});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_tx_after_rst", bus.tx, 1'b1);
    check_eq("t5_state_after_rst", bus.diag_state, 3'd0);
    check_eq("t5_busy_after_rst", bus.busy, 1'b0);
    check_eq("t5_reads_before", nreads - base_r, 1);
    wait_frames(base_f + 1, 120, "t5_next_frame");
    wait_state(3'd0, 10, "t5_final_idle");
    check_eq("t5_reads_total", nreads - base_r, 2);
    check_eq("t5_fifo_drained", fifo_q.size(), 0);

    // Random writer into a DEPTH-entry FIFO with random enable gaps; stream must be 1,2,3,...
    tick();
    base_f   = nframes;
    next_val = 1;
    wr       = 0;
    guard    = 0;
    while (wr < 40 && guard < 6000) begin
      tick();
      guard++;
      if (fifo_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        fifo_push(8'(next_val));
        next_val++;
        wr++;
      end
      if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
    end
    tick();
    bus.en = 1'b1;
    wait_frames(base_f + 40, 40 * 60, "t6_all_frames");
    wait_state(3'd0, 20, "t6_final_idle");
    check_eq("t6_written", wr, 40);
    check_eq("t6_no_leftover_expected", exp_q.size(), 0);
    check_eq("t6_fifo_drained", fifo_q.size(), 0);
    check_eq("total_reads_vs_frames", nreads, nframes + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Drain stage that sits directly downstream of fifo_diag. Whenever the FIFO is non-empty and the block is enabled, it pops one byte and serialises it as an 8N1 UART frame on a single tx line. It owns the FIFO read handshake, so the FIFO's read/rdata/empty port connects straight to it. It also exports diag outputs in the same style as fifo_diag.

Parameters:
CLKS_PER_BIT, 4, clock cycles per UART bit; must be >= 2 (elaboration-time check)
CNT_WIDTH, $clog2(CLKS_PER_BIT), width of the baud counter

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous active-high reset
en  input  1  enable; start a new frame only while high
fifo_empty  input  1  FIFO empty flag
fifo_read  output  1  FIFO read strobe; high for exactly one cycle per pop
fifo_rdata  input  8  FIFO read data; valid the cycle after fifo_read is high
tx  output  1  serial line; idle high
busy  output  1  high from the POP state through the end of STOP
diag_state  output  3  current FSM state encoding
diag_bit  output  3  index of the data bit currently being sent

Behaviour:
- Reset (sync, rst=1 at a posedge):
  - state=IDLE, tx=1, fifo_read=0, busy=0, diag_bit=0, baud counter=0, shift register=0.
  - rst takes priority over every transition.
- FSM encoding: IDLE=0, POP=1, LOAD=2, START=3, DATA=4, STOP=5. All outputs are registered or decoded from state, with no combinational path from inputs to outputs.
- IDLE: tx=1. If en=1 and fifo_empty=0 at the edge, go to POP; otherwise stay.
- POP (1 cycle): fifo_read=1. Next state is LOAD.
- LOAD (1 cycle): fifo_read=0. At the end of LOAD, latch fifo_rdata into the 8-bit shift register. Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with diag_bit=0.
- DATA:
  - tx = shift[0], LSB first.
  - Each bit is held for CLKS_PER_BIT cycles, after which the register shifts right and diag_bit increments.
  - After bit 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if en=1 and fifo_empty=0, go directly to POP;
  - otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change.
  - A bit period ends when count==CLKS_PER_BIT-1.
- Latency:
  - fifo_empty sampled low in IDLE at edge t gives fifo_read high in cycle t+1 and tx falling in cycle t+3.
  - A frame lasts 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly 2 idle-high cycles (POP and LOAD).
- busy=1 in states POP..STOP and 0 in IDLE.
- Boundary conditions:
  - fifo_read is never asserted unless fifo_empty was 0 in the deciding cycle.
  - At most one pop per frame, so the block never underflows the FIFO.
  - en dropping mid-frame: the current frame completes normally; no further pop follows.
  - fifo_empty changing during a frame is ignored until the STOP decision.
  - rst mid-frame: tx returns to 1 at the next edge. The popped byte is discarded and is not re-read.
  - Simultaneous FIFO write and this block's read is the FIFO's concern; this block only obeys the empty flag.

Test Plan:
1. Reset, then idle (rst high for 1 cycle, en=1, fifo_empty=1) -> tx=1, fifo_read=0, busy=0, diag_state=0 for 20 cycles.
2. Single byte (CLKS_PER_BIT=4, FIFO holds 0xA5, en=1) -> fifo_read high for exactly 1 cycle. tx shows 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles, 40 cycles total. The start bit falls 3 cycles after the first IDLE edge with empty=0. The FIFO is empty afterwards and the FSM returns to IDLE.
3. Back-to-back (FIFO preloaded with 0x01,0x02,0x03) -> three frames, each with 2 high cycles between the end of STOP and the next start bit. The decoded bytes are 01,02,03. Exactly 3 read pulses; fifo_read is never high while empty=1.
4. Enable gating (load 2 bytes, drop en during the first frame's DATA state) -> the first frame completes, no second pop occurs, and the FIFO still holds 1 byte. Raising en again sends the second byte.
5. Reset mid-frame (assert rst during DATA bit 3) -> at the next edge tx=1, state=IDLE, busy=0. After release, the next FIFO byte is sent intact.
6. Integration with fifo_diag (DEPTH=4, writer filling continuously) -> the serial byte stream equals the write sequence 1,2,3..., with no drops or duplicates, and FIFO full/empty behave consistently.
